// File: rtl/keccak_pkg.sv
// ============================================================================
// keccak_pkg: shared SHAKE256 rate geometry, padding bytes and loader states.
// Rev 1.0
// ============================================================================
`default_nettype none

package keccak_pkg;

  localparam int         RATE_BITS    = 1088;
  localparam int         RATE_WORDS   = 17;
  localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
  localparam logic [7:0] PAD_LAST     = 8'h80;

  typedef logic [RATE_BITS-1:0] rate_block_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    FINAL = 2'd2
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/shake_block_loader.sv
// ============================================================================
// shake_block_loader: packs 64-bit message words into SHAKE256 rate blocks and
// applies the 0x1F ... 0x80 multi-rate padding. Rev 1.0
// ============================================================================
`default_nettype none

module shake_block_loader #(
  parameter int RATE_WORDS = 17,
  parameter int WORD_W     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_last,
  input  logic [3:0]                   in_bytes,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [RATE_WORDS*WORD_W-1:0] blk_data,
  output logic                         blk_last
);

  import keccak_pkg::*;

  localparam int                BYTES_W    = WORD_W / 8;
  localparam int                BLK_W      = RATE_WORDS * WORD_W;
  localparam int                WCNT_W     = $clog2(RATE_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(RATE_WORDS - 1);
  localparam logic [3:0]        FULL_BYTES = 4'(BYTES_W);

  loader_state_e     state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              spill_q, spill_d;
  logic [BLK_W-1:0]  buf_q, buf_d;

  logic [3:0]        w_nbytes;
  logic              w_accept;
  logic              w_at_last;
  logic              w_spill;

  // Keep the first nbytes bytes, drop the rest, and drop the suffix right after them.
  function automatic logic [WORD_W-1:0] pack_last(input logic [WORD_W-1:0] data,
                                                  input logic [3:0]        nbytes);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < BYTES_W; k++) begin
      if (4'(k) < nbytes) begin
        w[8*k +: 8] = data[8*k +: 8];
      end else if (4'(k) == nbytes) begin
        w[8*k +: 8] = SHAKE_SUFFIX;
      end
    end
    return w;
  endfunction

  assign w_nbytes  = (in_bytes > FULL_BYTES) ? FULL_BYTES : in_bytes;
  assign w_accept  = (state_q == FILL) && in_valid;
  assign w_at_last = (wcnt_q == LAST_WORD);
  assign w_spill   = in_last && (w_nbytes == FULL_BYTES) && w_at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      spill_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      spill_q <= spill_d;
      buf_q   <= buf_d;
      if (w_accept && in_last) begin
        assert (in_bytes <= FULL_BYTES)
          else $error("shake_block_loader: in_bytes=%0d out of range", in_bytes);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (w_accept) begin
          if (in_last) begin
            state_d = w_spill ? FULL : FINAL;
          end else if (w_at_last) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (blk_ready) begin
          state_d = spill_q ? FINAL : FILL;
        end
      end
      FINAL: begin
        if (blk_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    unique case (state_q)
      FILL:  in_ready = !rst;
      FULL:  blk_valid = 1'b1;
      FINAL: begin
        blk_valid = 1'b1;
        blk_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign blk_data = buf_q;

  always_comb begin
    buf_d   = buf_q;
    wcnt_d  = wcnt_q;
    spill_d = spill_q;
    unique case (state_q)
      FILL: begin
        if (w_accept) begin
          for (int i = 0; i < RATE_WORDS; i++) begin
            if (wcnt_q == WCNT_W'(i)) begin
              buf_d[i*WORD_W +: WORD_W] = in_last ? pack_last(in_data, w_nbytes) : in_data;
            end
          end
          if (in_last) begin
            // A full final word pushes the suffix into byte 0 of the next word.
            if ((w_nbytes == FULL_BYTES) && !w_at_last) begin
              for (int i = 1; i < RATE_WORDS; i++) begin
                if ((wcnt_q + WCNT_W'(1)) == WCNT_W'(i)) begin
                  buf_d[i*WORD_W +: 8] = buf_d[i*WORD_W +: 8] | SHAKE_SUFFIX;
                end
              end
            end
            if (w_spill) begin
              spill_d = 1'b1;
            end else begin
              buf_d[BLK_W-8 +: 8] = buf_d[BLK_W-8 +: 8] | PAD_LAST;
            end
          end else if (!w_at_last) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      FULL: begin
        if (blk_ready) begin
          buf_d   = '0;
          spill_d = 1'b0;
          if (spill_q) begin
            buf_d[7:0]          = SHAKE_SUFFIX;
            buf_d[BLK_W-8 +: 8] = PAD_LAST;
          end else begin
            wcnt_d = '0;
          end
        end
      end
      FINAL: begin
        if (blk_ready) begin
          buf_d  = '0;
          wcnt_d = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_shake_block_loader.sv
// ============================================================================
// tb_shake_block_loader: directed and random messages against a byte-level
// SHAKE256 padding reference. Rev 1.0
// ============================================================================
`default_nettype none

module tb_shake_block_loader;

  localparam int NB = 136;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [1087:0] blk_data;
  logic          blk_last;

  int            tests = 0;
  int            fails = 0;
  logic [7:0]    msg[$];
  logic [1087:0] exp_q[$];
  bit            exp_last_q[$];
  logic [1087:0] got_blk;

  always #5 clk = ~clk;

  shake_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1087:0] got, input logic [1087:0] exp);
    tests++;
    assert (got === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic chkb(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
  endtask

  // Reference: append 0x1F, zero-fill to a rate multiple, OR 0x80 into the final byte.
  task automatic build_ref();
    logic [7:0]    p[$];
    logic [1087:0] blk;
    int            nblk;
    p = msg;
    p.push_back(8'h1F);
    while (p.size() % NB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / NB;
    exp_q.delete();
    exp_last_q.delete();
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < NB; j++) blk[8*j +: 8] = p[NB*b + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic take_block(input int stall);
    logic [1087:0] e;
    bit            el;
    int            st;
    e  = exp_q.pop_front();
    el = exp_last_q.pop_front();
    st = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
    chkb("blk_valid", blk_valid, 1);
    chk("blk_data", blk_data, e);
    chkb("blk_last", blk_last, el);
    chkb("in_ready_handoff", in_ready, 0);
    got_blk = blk_data;
    for (int s = 0; s < st; s++) begin
      tick();
      chkb("stall_valid", blk_valid, 1);
      chk("stall_data", blk_data, e);
      chkb("stall_last", blk_last, el);
      chkb("stall_in_ready", in_ready, 0);
    end
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  task automatic run_msg(input bit zero_tail, input int max_gap, input int stall, input bit garbage);
    int          n, nw, lastb, inblk, idx;
    logic [63:0] d;
    build_ref();
    n     = msg.size();
    nw    = (n == 0) ? 1 : (n + 7) / 8;
    lastb = n - 8 * (nw - 1);
    if (zero_tail && n > 0 && (n % 8) == 0) begin
      nw++;
      lastb = 0;
    end
    inblk = 0;
    for (int w = 0; w < nw; w++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick();
      d = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) begin
        idx = 8 * w + k;
        if (idx < n) d[8*k +: 8] = msg[idx];
        else if (!garbage) d[8*k +: 8] = 8'h00;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == nw - 1);
      in_bytes = (w == nw - 1) ? 4'(lastb) : 4'($urandom_range(15, 0));
      chkb("in_ready_fill", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      inblk++;
      if (inblk == 17 || w == nw - 1) begin
        inblk = 0;
        chkb("block_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) take_block(stall);
      end
    end
    while (exp_q.size() > 0) take_block(stall);
    chkb("idle_in_ready", in_ready, 1);
    chkb("idle_blk_valid", blk_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    blk_ready = 1'b0;
    tick();
    tick();
    chkb("rst_in_ready", in_ready, 0);
    chkb("rst_blk_valid", blk_valid, 0);
    chkb("rst_blk_last", blk_last, 0);
    chk("rst_blk_data", blk_data, '0);
    rst = 1'b0;
    #1;
    chkb("post_rst_in_ready", in_ready, 1);

    // Empty message
    msg.delete();
    run_msg(1'b0, 0, 0, 1'b1);
    chk("empty_block", got_blk, {1'b1, 1079'b0, 8'h1F});

    // Three-byte message
    msg = '{8'hAA, 8'hBB, 8'hCC};
    run_msg(1'b0, 0, 0, 1'b0);
    chk("word0_3bytes", {1024'b0, got_blk[63:0]}, {1024'b0, 64'h000000001FCCBBAA});
    chk("byte135_3bytes", {1080'b0, got_blk[1087:1080]}, {1080'b0, 8'h80});

    // 16 full words: suffix lands in word 16 byte 0
    msg.delete();
    repeat (128) msg.push_back(8'($urandom));
    run_msg(1'b0, 1, 1, 1'b1);
    chk("word16_after_16full", {1024'b0, got_blk[1087:1024]}, {1024'b0, 64'h800000000000001F});

    // 135 bytes: suffix and final pad share byte 135
    msg.delete();
    repeat (135) msg.push_back(8'($urandom));
    run_msg(1'b0, 0, 2, 1'b1);
    chk("byte135_shared", {1080'b0, got_blk[1087:1080]}, {1080'b0, 8'h9F});

    // 136 bytes ending on a full word 16: spill block
    msg.delete();
    repeat (136) msg.push_back(8'($urandom));
    run_msg(1'b0, 0, 0, 1'b1);
    chk("spill_block", got_blk, {8'h80, 1072'b0, 8'h1F});

    // Two-block message with long back-pressure
    msg.delete();
    repeat (200) msg.push_back(8'($urandom));
    run_msg(1'b0, 1, 5, 1'b1);

    // Reset after five accepted words
    for (int w = 0; w < 5; w++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chkb("midrst_in_ready", in_ready, 0);
    tick();
    chkb("midrst_blk_valid", blk_valid, 0);
    rst = 1'b0;
    #1;
    chkb("midrst_release_in_ready", in_ready, 1);
    msg.delete();
    repeat (5) msg.push_back(8'($urandom));
    run_msg(1'b0, 0, 0, 1'b1);

    // Random messages
    for (int r = 0; r < 20; r++) begin
      msg.delete();
      repeat ($urandom_range(300, 0)) msg.push_back(8'($urandom));
      run_msg(1'($urandom_range(1, 0)), 2, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shake_block_loader.md
# shake_block_loader

Front end of the SHAKE256 datapath. It accepts a message as a stream of 64-bit words, packs the words into 1088-bit rate blocks and applies SHAKE256 multi-rate padding (domain suffix 0x1F, final 0x80). Each finished block goes to the absorb stage over a valid/ready handshake. Bit layout of `blk_data` matches the absorber rate mapping: word i occupies bits [64i+63:64i], which is lane (row = i/5, col = i%5).

## Interface
- `RATE_WORDS`, default 17: 64-bit words per rate block (1088 bits).
- `WORD_W`, default 64: input word width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  64  message word, little-endian byte lanes (byte k at [8k+7:8k]).
- `in_last`  in  1  final word of the message.
- `in_bytes`  in  4  valid bytes in the last word, 0..8. Ignored when `in_last`=0.
- `blk_valid`  out  1  `blk_data` holds a complete block.
- `blk_ready`  in  1  absorb stage takes the block.
- `blk_data`  out  1088  rate block.
- `blk_last`  out  1  block is the final, padded block of the message.

## Operation
States:
- FILL: `in_ready`=1.
- FULL: `blk_valid`=1, `blk_last`=0.
- FINAL: `blk_valid`=1, `blk_last`=1.

Word counter `wcnt` runs 0..16. Buffer `buf` is 1088 bits.

- FILL, accepting a word with `in_last`=0: write `buf[wcnt]`. If `wcnt`=16, go to FULL; otherwise `wcnt`++.
- FILL, accepting a word with `in_last`=1:
  - Write the word with bytes ≥ `in_bytes` zeroed.
  - If `in_bytes`<8, OR 0x1F into byte `in_bytes` of word `wcnt`.
  - If `in_bytes`=8 and `wcnt`<16, OR 0x1F into byte 0 of word `wcnt`+1 in the same cycle.
  - Unless spilling (next bullet), OR 0x80 into byte 135 (bit 1087) and go to FINAL.
  - If `in_bytes`=8 and `wcnt`=16, set `spill`=1 and go to FULL without padding.
- FULL, on `blk_ready`:
  - If `spill`=1: load `buf` with 0x1F at byte 0 and 0x80 at byte 135, clear `spill`, go to FINAL.
  - Otherwise clear `buf`, set `wcnt`=0, go to FILL.
- FINAL, on `blk_ready`: clear `buf`, set `wcnt`=0, go to FILL.
- If 0x1F and 0x80 land on the same byte (byte 135), that byte is 0x9F.
- `in_bytes` values 9..15 are illegal. The design treats them as 8, and simulation fires an assertion.
- The empty message (`in_last`=1, `in_bytes`=0 at `wcnt`=0) produces a single final block.

## Timing
- Reset values: state FILL, `wcnt`=0, `spill`=0, `buf`=0, `blk_valid`=0, `blk_last`=0, `blk_data`=0. `in_ready` is forced to 0 while `rst`=1 and is 1 in the first cycle after reset.
- `blk_valid` rises in the cycle after the accepting edge of the 17th word or the last word.
- `blk_data` and `blk_last` are registered and stay stable while `blk_valid`=1 and `blk_ready`=0.
- `in_ready`=0 in FULL and FINAL. There is no overlap between fill and handoff.
- A full block costs at least 18 cycles: 17 accepts plus 1 handoff.
- No combinational path from `blk_ready` or `in_valid` to any output. `in_ready` depends only on state and `rst`.
- A spill block appears the cycle after the first handoff.
- `rst` asserted mid-message or mid-handoff discards everything, including any pending `spill`. The next accepted word is word 0 of a new message.

## Structure
- `keccak_pkg` holds `RATE_BITS`=1088, `RATE_WORDS`=17, `SHAKE_SUFFIX`=8'h1F, `PAD_LAST`=8'h80, `typedef logic [1087:0] rate_block_t`, and `typedef enum {FILL, FULL, FINAL} loader_state_e`.
- Single module. Byte masking and suffix insertion are a combinational function inside it; no sub-module.

## Test plan
- Empty message (`in_last`=1, `in_bytes`=0) -> one block, bits[7:0]=0x1F, bit 1087=1, all other bits 0, `blk_last`=1.
- One word 0x0000000000CCBBAA with `in_bytes`=3 -> word 0 = 0x000000001FCCBBAA, byte 135=0x80, `blk_last`=1.
- 16 full words, last with `in_bytes`=8 on word 15 -> one block, word 16 = 0x800000000000001F. Repeat with `in_bytes`=7 on word 16 -> byte 135=0x9F.
- 17 full words, last on word 16 with `in_bytes`=8 -> block 1 is the data with `blk_last`=0; block 2 has byte 0=0x1F, byte 135=0x80, `blk_last`=1, and is valid the cycle after handoff 1.
- Two-block message with `blk_ready` held low for 5 cycles -> `blk_data` stable, `in_ready`=0, no input word lost or duplicated, compared against a reference padder.
- `rst` pulsed after 5 accepted words -> `blk_valid`=0, a new 1-word message yields a block with no residue from the earlier words.
